// File: rtl/commit_controller.sv
// commit_controller
//   In-order retire sequencer sitting between the reorder-buffer head and
//   architectural state. It retires the head instruction, writes the register
//   file, performs store writes at commit, and detects branch/JALR mispredicts.
//   A mispredict raises a one-cycle global flush together with a fetch redirect.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   commit_*        ROB head: valid, tag, op, rd, value, pc, actual target or
//                   store address, predicted-taken, actual-taken, predicted target
//   commit_ack      head retires this cycle (combinational)
//   rf_we/waddr/wdata/rob_id
//                   register file write port (combinational pass-through of head)
//   st_req/ready/op/addr/data/done
//                   store port; st_req and the st_* fields are registered
//   flush_o, redirect_valid, redirect_pc
//                   registered one-cycle flush and fetch redirect
//   retire_cnt, mispred_cnt
//                   wrapping performance counters
module commit_controller #(
  parameter int PC_INC     = 4,
  parameter int CNT_W      = 32,
  parameter int ROB_ID_W   = 4,
  parameter int OP_W       = 8,
  parameter int REG_ADDR_W = 5,
  parameter int REG_W      = 32,
  parameter int ADDR_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  commit_valid,
  input  logic [ROB_ID_W-1:0]   commit_id,
  input  logic [OP_W-1:0]       commit_op,
  input  logic [REG_ADDR_W-1:0] commit_rd,
  input  logic [REG_W-1:0]      commit_value,
  input  logic [ADDR_W-1:0]     commit_pc,
  input  logic [ADDR_W-1:0]     commit_addr,
  input  logic                  commit_pred,
  input  logic                  commit_outcome,
  input  logic [ADDR_W-1:0]     commit_pred_tgt,
  output logic                  commit_ack,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [REG_W-1:0]      rf_wdata,
  output logic [ROB_ID_W-1:0]   rf_rob_id,
  output logic                  st_req,
  input  logic                  st_ready,
  output logic [OP_W-1:0]       st_op,
  output logic [ADDR_W-1:0]     st_addr,
  output logic [REG_W-1:0]      st_data,
  input  logic                  st_done,
  output logic                  flush_o,
  output logic                  redirect_valid,
  output logic [ADDR_W-1:0]     redirect_pc,
  output logic [CNT_W-1:0]      retire_cnt,
  output logic [CNT_W-1:0]      mispred_cnt
);

  // Operation encodings shared with the decode stage.
  localparam logic [OP_W-1:0] OP_BEQ  = 8'h51;
  localparam logic [OP_W-1:0] OP_BNE  = 8'h52;
  localparam logic [OP_W-1:0] OP_BLT  = 8'h53;
  localparam logic [OP_W-1:0] OP_BGE  = 8'h54;
  localparam logic [OP_W-1:0] OP_BLTU = 8'h55;
  localparam logic [OP_W-1:0] OP_BGEU = 8'h56;
  localparam logic [OP_W-1:0] OP_SB   = 8'h38;
  localparam logic [OP_W-1:0] OP_SH   = 8'h39;
  localparam logic [OP_W-1:0] OP_SW   = 8'h3a;
  localparam logic [OP_W-1:0] OP_JALR = 8'h4a;

  typedef enum logic [1:0] {
    S_COMMIT,
    S_STORE_REQ,
    S_STORE_WAIT,
    S_FLUSH
  } state_t;

  state_t state;

  logic              is_branch;
  logic              is_store;
  logic              is_jalr;
  logic              br_mispred;
  logic              jalr_mispred;
  logic              mispred;
  logic [ADDR_W-1:0] flush_tgt;
  logic              head_retire;
  logic              store_done;

  // Head classification and mispredict detection.
  always_comb begin
    is_branch    = commit_op inside {OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU};
    is_store     = commit_op inside {OP_SB, OP_SH, OP_SW};
    is_jalr      = (commit_op == OP_JALR);
    // A taken/taken branch can still be wrong if the predicted target differs.
    br_mispred   = (commit_pred != commit_outcome) ||
                   (commit_pred && commit_outcome && (commit_pred_tgt != commit_addr));
    jalr_mispred = (commit_pred_tgt != commit_addr);
    mispred      = (is_branch && br_mispred) || (is_jalr && jalr_mispred);
    if (is_jalr || commit_outcome) flush_tgt = commit_addr;
    else                           flush_tgt = commit_pc + ADDR_W'(PC_INC);
  end

  // Retire decisions. Reset masks both paths so nothing retires while the
  // sequencer is being cleared. A st_done seen alongside st_ready completes
  // the store immediately, skipping STORE_WAIT.
  always_comb begin
    head_retire = !rst && (state == S_COMMIT) && commit_valid && !is_store;
    store_done  = !rst && st_done &&
                  ((state == S_STORE_WAIT) || ((state == S_STORE_REQ) && st_ready));
    commit_ack  = head_retire || store_done;
    rf_we       = head_retire && !is_branch && (commit_rd != '0);
    rf_waddr    = commit_rd;
    rf_wdata    = commit_value;
    rf_rob_id   = commit_id;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_COMMIT;
      st_req         <= 1'b0;
      st_op          <= '0;
      st_addr        <= '0;
      st_data        <= '0;
      flush_o        <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      retire_cnt     <= '0;
      mispred_cnt    <= '0;
    end else begin
      // Flush is a single-cycle pulse; only the COMMIT mispredict path raises it.
      flush_o        <= 1'b0;
      redirect_valid <= 1'b0;
      if (commit_ack) retire_cnt <= retire_cnt + CNT_W'(1);

      unique case (state)
        S_COMMIT: begin
          if (commit_valid) begin
            if (is_store) begin
              st_req  <= 1'b1;
              st_op   <= commit_op;
              st_addr <= commit_addr;
              st_data <= commit_value;
              state   <= S_STORE_REQ;
            end else if (mispred) begin
              mispred_cnt    <= mispred_cnt + CNT_W'(1);
              redirect_pc    <= flush_tgt;
              flush_o        <= 1'b1;
              redirect_valid <= 1'b1;
              state          <= S_FLUSH;
            end
          end
        end
        S_STORE_REQ: begin
          // st_* stay frozen until the memory accepts the request.
          if (st_ready) begin
            st_req <= 1'b0;
            state  <= st_done ? S_COMMIT : S_STORE_WAIT;
          end
        end
        S_STORE_WAIT: begin
          if (st_done) state <= S_COMMIT;
        end
        S_FLUSH: begin
          // Head is being squashed this cycle; never retire here.
          state <= S_COMMIT;
        end
        default: state <= S_COMMIT;
      endcase
    end
  end

endmodule

// File: tb/tb_commit_controller.sv
// Directed bench for commit_controller. Stimulus pushes the expected retire,
// flush and store-accept events into queues; a negedge monitor pops and
// compares whenever the DUT presents one of those events.
module tb_commit_controller;

  localparam logic [7:0] ADD  = 8'h20;
  localparam logic [7:0] LW   = 8'h23;
  localparam logic [7:0] BEQ  = 8'h51;
  localparam logic [7:0] BNE  = 8'h52;
  localparam logic [7:0] BGE  = 8'h54;
  localparam logic [7:0] BLTU = 8'h55;
  localparam logic [7:0] SB   = 8'h38;
  localparam logic [7:0] SH   = 8'h39;
  localparam logic [7:0] SW   = 8'h3a;
  localparam logic [7:0] JALR = 8'h4a;

  logic        clk = 1'b0;
  logic        rst;
  logic        commit_valid;
  logic [3:0]  commit_id;
  logic [7:0]  commit_op;
  logic [4:0]  commit_rd;
  logic [31:0] commit_value, commit_pc, commit_addr, commit_pred_tgt;
  logic        commit_pred, commit_outcome;
  logic        commit_ack, rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [3:0]  rf_rob_id;
  logic        st_req, st_ready, st_done;
  logic [7:0]  st_op;
  logic [31:0] st_addr, st_data;
  logic        flush_o, redirect_valid;
  logic [31:0] redirect_pc, retire_cnt, mispred_cnt;

  commit_controller dut (
    .clk(clk), .rst(rst),
    .commit_valid(commit_valid), .commit_id(commit_id), .commit_op(commit_op),
    .commit_rd(commit_rd), .commit_value(commit_value), .commit_pc(commit_pc),
    .commit_addr(commit_addr), .commit_pred(commit_pred), .commit_outcome(commit_outcome),
    .commit_pred_tgt(commit_pred_tgt),
    .commit_ack(commit_ack), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_rob_id(rf_rob_id),
    .st_req(st_req), .st_ready(st_ready), .st_op(st_op), .st_addr(st_addr),
    .st_data(st_data), .st_done(st_done),
    .flush_o(flush_o), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .retire_cnt(retire_cnt), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { logic we; logic [4:0] rd; logic [31:0] data; logic [3:0] id; } ack_t;
  typedef struct { logic [7:0] op; logic [31:0] addr; logic [31:0] data; } st_t;

  ack_t        ack_q[$];
  logic [31:0] flush_q[$];
  st_t         st_q[$];

  int compared = 0;
  int mismatched = 0;
  bit started = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bad(input string name, input logic [63:0] act);
    compared++;
    mismatched++;
    $display("FAIL %s: got %0h expected no event at %0t", name, act, $time);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] op, input logic [4:0] rd, input logic [31:0] val,
                       input logic [31:0] pc, input logic [31:0] addr, input logic pred,
                       input logic outc, input logic [31:0] tgt, input logic [3:0] id);
    commit_valid = 1'b1; commit_op = op; commit_rd = rd; commit_value = val;
    commit_pc = pc; commit_addr = addr; commit_pred = pred; commit_outcome = outc;
    commit_pred_tgt = tgt; commit_id = id;
  endtask

  task automatic idle;
    commit_valid = 1'b0;
  endtask

  task automatic exp_ack(input logic we, input logic [4:0] rd, input logic [31:0] d,
                         input logic [3:0] id);
    ack_t e;
    e.we = we; e.rd = rd; e.data = d; e.id = id;
    ack_q.push_back(e);
  endtask

  task automatic exp_st(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d);
    st_t e;
    e.op = op; e.addr = a; e.data = d;
    st_q.push_back(e);
  endtask

  // Monitor: compares DUT events against queued expectations.
  always @(negedge clk) begin
    if (started) begin
      if (commit_ack) begin
        if (ack_q.size() == 0) bad("unexpected_ack", commit_ack);
        else begin
          ack_t e;
          e = ack_q.pop_front();
          chk("ack_rf_we", rf_we, e.we);
          if (e.we) begin
            chk("ack_waddr", rf_waddr, e.rd);
            chk("ack_wdata", rf_wdata, e.data);
            chk("ack_rob_id", rf_rob_id, e.id);
          end
        end
      end else if (rf_we) bad("rf_we_without_ack", rf_we);

      if (flush_o) begin
        if (flush_q.size() == 0) bad("unexpected_flush", redirect_pc);
        else begin
          logic [31:0] t;
          t = flush_q.pop_front();
          chk("redirect_valid", redirect_valid, 1'b1);
          chk("redirect_pc", redirect_pc, t);
        end
      end else if (redirect_valid) bad("redirect_without_flush", redirect_valid);

      if (st_req && st_ready) begin
        if (st_q.size() == 0) bad("unexpected_store", st_addr);
        else begin
          st_t e;
          e = st_q.pop_front();
          chk("st_op", st_op, e.op);
          chk("st_addr", st_addr, e.addr);
          chk("st_data", st_data, e.data);
        end
      end
    end
  end

  // Hard bound on the whole run.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; st_ready = 1'b0; st_done = 1'b0;
    drive(ADD, 5'd4, 32'h1, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 4'd0);
    @(posedge clk); #1; started = 1;
    @(negedge clk);
    chk("rst_st_req", st_req, 1'b0);
    chk("rst_flush", flush_o, 1'b0);
    chk("rst_redirect_pc", redirect_pc, 32'h0);
    chk("rst_retire_cnt", retire_cnt, 32'h0);
    chk("rst_mispred_cnt", mispred_cnt, 32'h0);
    chk("rst_ack", commit_ack, 1'b0);
    tick; rst = 1'b0;

    // ADD rd=5
    drive(ADD, 5'd5, 32'h1234, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 4'd1);
    exp_ack(1'b1, 5'd5, 32'h1234, 4'd1);
    tick; idle;
    @(negedge clk); chk("retire_after_add", retire_cnt, 32'd1);

    // ADD rd=0: retires, no write
    tick;
    drive(ADD, 5'd0, 32'h55, 32'h14, 32'h0, 1'b0, 1'b0, 32'h0, 4'd2);
    exp_ack(1'b0, 5'd0, 32'h55, 4'd2);
    tick; idle;

    // BEQ predicted taken, not taken: fall-through redirect; head in FLUSH not acked
    drive(BEQ, 5'd0, 32'h0, 32'h100, 32'h180, 1'b1, 1'b0, 32'h180, 4'd3);
    exp_ack(1'b0, 5'd0, 32'h0, 4'd3);
    flush_q.push_back(32'h104);
    tick;
    drive(ADD, 5'd7, 32'h77, 32'h104, 32'h0, 1'b0, 1'b0, 32'h0, 4'd4);
    @(negedge clk); chk("mispred_beq", mispred_cnt, 32'd1);
    tick; idle;
    @(negedge clk);
    chk("flush_one_cycle", flush_o, 1'b0);
    chk("retire_after_beq", retire_cnt, 32'd3);

    // BNE taken/taken with wrong target
    tick;
    drive(BNE, 5'd0, 32'h0, 32'h300, 32'h240, 1'b1, 1'b1, 32'h200, 4'd5);
    exp_ack(1'b0, 5'd0, 32'h0, 4'd5);
    flush_q.push_back(32'h240);
    tick; idle; tick;

    // BNE taken/taken with right target: no flush
    drive(BNE, 5'd0, 32'h0, 32'h300, 32'h240, 1'b1, 1'b1, 32'h240, 4'd6);
    exp_ack(1'b0, 5'd0, 32'h0, 4'd6);
    tick; idle;
    @(negedge clk);
    chk("bne_hit_no_flush", flush_o, 1'b0);
    chk("mispred_bne", mispred_cnt, 32'd2);

    // BGE predicted not-taken, taken -> redirect to addr
    tick;
    drive(BGE, 5'd3, 32'h9, 32'h400, 32'h480, 1'b0, 1'b1, 32'h0, 4'd7);
    exp_ack(1'b0, 5'd0, 32'h0, 4'd7);
    flush_q.push_back(32'h480);
    tick; idle; tick;

    // BLTU correctly predicted not-taken
    drive(BLTU, 5'd0, 32'h0, 32'h500, 32'h5a0, 1'b0, 1'b0, 32'h5a0, 4'd8);
    exp_ack(1'b0, 5'd0, 32'h0, 4'd8);
    tick;

    // JALR wrong target: writes link register and redirects to addr
    drive(JALR, 5'd1, 32'h504, 32'h500, 32'h700, 1'b1, 1'b1, 32'h600, 4'd9);
    exp_ack(1'b1, 5'd1, 32'h504, 4'd9);
    flush_q.push_back(32'h700);
    tick; idle; tick;

    // JALR correct target
    drive(JALR, 5'd2, 32'h704, 32'h700, 32'h800, 1'b1, 1'b1, 32'h800, 4'd10);
    exp_ack(1'b1, 5'd2, 32'h704, 4'd10);
    tick;

    // Fall-through redirect wraps at 32 bits
    drive(BEQ, 5'd0, 32'h0, 32'hFFFF_FFFC, 32'h40, 1'b1, 1'b0, 32'h40, 4'd11);
    exp_ack(1'b0, 5'd0, 32'h0, 4'd11);
    flush_q.push_back(32'h0);
    tick; idle; tick;

    // LW rd=31
    drive(LW, 5'd31, 32'hCAFE_F00D, 32'h0, 32'h900, 1'b0, 1'b0, 32'h0, 4'd12);
    exp_ack(1'b1, 5'd31, 32'hCAFE_F00D, 4'd12);
    tick; idle;
    @(negedge clk);
    chk("retire_mid", retire_cnt, 32'd11);
    chk("mispred_mid", mispred_cnt, 32'd5);

    // SW: st_ready low 3 cycles, then high; st_done 2 cycles after acceptance
    tick;
    drive(SW, 5'd0, 32'hDEAD, 32'hA00, 32'h1000, 1'b0, 1'b0, 32'h0, 4'd13);
    exp_st(SW, 32'h1000, 32'hDEAD);
    @(negedge clk); chk("sw_req_registered", st_req, 1'b0);
    tick;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("sw_req_held", st_req, 1'b1);
      tick;
    end
    st_ready = 1'b1;
    @(negedge clk); chk("sw_req_4th", st_req, 1'b1);
    tick; st_ready = 1'b0;
    @(negedge clk); chk("sw_req_dropped", st_req, 1'b0);
    tick; st_done = 1'b1;
    exp_ack(1'b0, 5'd0, 32'h0, 4'd13);
    tick; st_done = 1'b0; idle;
    @(negedge clk); chk("retire_after_sw", retire_cnt, 32'd12);

    // SH: st_done together with st_ready completes at once
    tick;
    drive(SH, 5'd0, 32'hBEEF, 32'hA04, 32'h2002, 1'b0, 1'b0, 32'h0, 4'd14);
    tick;
    st_ready = 1'b1; st_done = 1'b1;
    exp_st(SH, 32'h2002, 32'hBEEF);
    exp_ack(1'b0, 5'd0, 32'h0, 4'd14);
    tick; st_ready = 1'b0; st_done = 1'b0;
    drive(ADD, 5'd3, 32'h33, 32'hA08, 32'h0, 1'b0, 1'b0, 32'h0, 4'd15);
    exp_ack(1'b1, 5'd3, 32'h33, 4'd15);
    tick; idle;
    @(negedge clk); chk("retire_after_sh", retire_cnt, 32'd14);

    // SB then reset in STORE_WAIT with st_done high: no retire
    tick;
    drive(SB, 5'd0, 32'hAA, 32'hA0C, 32'h3001, 1'b0, 1'b0, 32'h0, 4'd0);
    tick;
    st_ready = 1'b1;
    exp_st(SB, 32'h3001, 32'hAA);
    tick; st_ready = 1'b0;
    idle; rst = 1'b1; st_done = 1'b1;
    tick; rst = 1'b0; st_done = 1'b0;
    @(negedge clk);
    chk("rst2_st_req", st_req, 1'b0);
    chk("rst2_retire_cnt", retire_cnt, 32'd0);
    chk("rst2_mispred_cnt", mispred_cnt, 32'd0);
    tick;
    drive(ADD, 5'd9, 32'h99, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 4'd1);
    exp_ack(1'b1, 5'd9, 32'h99, 4'd1);
    tick; idle;
    @(negedge clk); chk("retire_after_rst", retire_cnt, 32'd1);
    tick; tick;

    chk("ack_q_drained", ack_q.size(), 0);
    chk("flush_q_drained", flush_q.size(), 0);
    chk("st_q_drained", st_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
